// File: rtl/seg7_capture.sv
// seg7_capture -- receive-side decoder for a multiplexed 7-segment bus.
//
// Watches the scanned digit strobes of a seg7decimal-style display driver.
// Each digit that is held stable long enough is decoded back to a hex
// nibble. The 16-bit value currently on the display is rebuilt from those
// nibbles.
//
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   a_to_g[6:0]    - segment lines, active-low, bit6 = a ... bit0 = g
//   an[3:0]        - digit strobes, active-low, an[0] = value[3:0]
//   dp             - decimal point, active-low
//   value[15:0]    - last complete reassembled value
//   dp_out[3:0]    - per-digit decimal point (1 = lit) for that frame
//   frame_valid    - one-cycle pulse when value/dp_out load
//   changed        - pulse with frame_valid when value differs from before
//   seg_err        - pulse on an undecodable accepted pattern or on more
//                    than one strobe low
//   frame_count    - completed frames, wraps
//   err_count      - seg_err pulses, saturates at all-ones

// One digit position: staging nibble, staging dp and its mask bit.
module seg7_digit_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap,     // accepted valid pattern for this digit
  input  logic       clr,     // frame completion clears the mask bit
  input  logic [3:0] nib,
  input  logic       dp_lit,
  output logic [3:0] nib_q,
  output logic       dp_q,
  output logic       full_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q  <= '0;
      dp_q   <= 1'b0;
      full_q <= 1'b0;
    end else begin
      if (cap) begin
        nib_q <= nib;
        dp_q  <= dp_lit;
      end
      // A capture in the completion cycle belongs to the next frame, so
      // it wins over the clear.
      if (cap)      full_q <= 1'b1;
      else if (clr) full_q <= 1'b0;
    end
  end
endmodule

module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       a_to_g,
  input  logic [3:0]       an,
  input  logic             dp,
  output logic [15:0]      value,
  output logic [3:0]       dp_out,
  output logic             frame_valid,
  output logic             changed,
  output logic             seg_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } sample_t;

  // Reset to an idle bus (blank, all segments off) rather than zeros, so
  // a quiet bus after reset never looks like an all-strobes-low error.
  localparam sample_t IDLE = '1;

  sample_t smp, smp_prev;
  logic [7:0] stab_cnt, stab_next;
  logic       diff, accept, blank, one_low, dec_ok, err_hit, frame_done;
  logic [4:0] dec;
  logic [3:0] dec_nib;
  logic [NUM_DIGITS-1:0]      cap_vec, mask, stage_dp;
  logic [NUM_DIGITS-1:0][3:0] stage_nib;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  // Input stage plus one cycle of history for the stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp      <= IDLE;
      smp_prev <= IDLE;
      stab_cnt <= '0;
    end else begin
      smp      <= '{an: an, seg: a_to_g, dp: dp};
      smp_prev <= smp;
      stab_cnt <= stab_next;
    end
  end

  always_comb begin
    diff      = (smp != smp_prev);
    stab_next = diff ? 8'd1 : ((stab_cnt == STAB) ? stab_cnt : stab_cnt + 8'd1);
    // Fire only on the transition into STAB; a saturated run stays quiet.
    accept    = (stab_next == STAB) && (diff || (stab_cnt != STAB));
    blank     = (smp.an == 4'hF);
    one_low   = $onehot(~smp.an);
    dec       = seg_decode(smp.seg);
    dec_ok    = dec[4];
    dec_nib   = dec[3:0];
    cap_vec   = (accept && one_low && dec_ok) ? ~smp.an : '0;
    err_hit   = accept && !blank && (!one_low || !dec_ok);
    frame_done = &mask;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    seg7_digit_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap    (cap_vec[g]),
      .clr    (frame_done),
      .nib    (dec_nib),
      .dp_lit (~smp.dp),
      .nib_q  (stage_nib[g]),
      .dp_q   (stage_dp[g]),
      .full_q (mask[g])
    );
  end

  // Output side: frame load and error accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      seg_err     <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_valid <= frame_done;
      changed     <= frame_done && (stage_nib != value);
      if (frame_done) begin
        value       <= stage_nib;
        dp_out      <= stage_dp;
        frame_count <= frame_count + CNT_W'(1);
      end
      seg_err <= err_hit;
      if (err_hit && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scans from the test plan followed by a
// randomized bus, all compared every cycle against a behavioural model
// built from the decode table and the acceptance/frame rules.
module tb_seg7_capture;
  localparam int STABLE = 4;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  a_to_g = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic        dp = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic        frame_valid, changed, seg_err;
  logic [15:0] frame_count, err_count;

  seg7_capture #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a_to_g(a_to_g), .an(an), .dp(dp),
    .value(value), .dp_out(dp_out), .frame_valid(frame_valid),
    .changed(changed), .seg_err(seg_err), .frame_count(frame_count),
    .err_count(err_count));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [11:0] m_last = 12'hFFF, m_ps = 12'hFFF, m_cur;
  int          m_run = 1;
  logic        m_pend = 1'b0;
  logic [15:0] m_stage = '0;
  logic [3:0]  m_sdp = '0, m_mask = '0;
  int          mz, midx, mnib;
  logic [15:0] e_value = '0, e_fc = '0, e_ec = '0;
  logic [3:0]  e_dp = '0;
  logic        e_fv = 1'b0, e_ch = 1'b0, e_err = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_last = 12'hFFF; m_run = 1; m_pend = 1'b0; m_ps = 12'hFFF;
      m_stage = '0; m_sdp = '0; m_mask = '0;
      e_value = '0; e_dp = '0; e_fv = 1'b0; e_ch = 1'b0; e_err = 1'b0;
      e_fc = '0; e_ec = '0;
    end else begin
      e_fv = 1'b0; e_ch = 1'b0; e_err = 1'b0;
      // Frame completes the edge after all four digits are held.
      if (m_mask == 4'hF) begin
        e_ch = (m_stage != e_value);
        e_value = m_stage; e_dp = m_sdp; e_fv = 1'b1;
        e_fc = e_fc + 16'd1; m_mask = '0;
      end
      // A sample whose run reached STABLE is acted on one edge later.
      if (m_pend) begin
        mz = 0; midx = 0; mnib = -1;
        for (int i = 0; i < 4; i++) if (!m_ps[8+i]) begin mz++; midx = i; end
        for (int k = 0; k < 16; k++) if (SEG[k] == m_ps[7:1]) mnib = k;
        if (mz == 1 && mnib >= 0) begin
          m_stage[4*midx +: 4] = mnib[3:0];
          m_sdp[midx] = ~m_ps[0];
          m_mask[midx] = 1'b1;
        end else if (mz >= 1) begin
          e_err = 1'b1;
          if (e_ec != 16'hFFFF) e_ec = e_ec + 16'd1;
        end
      end
      m_cur = {an, a_to_g, dp};
      if (m_cur == m_last) m_run++; else m_run = 1;
      m_last = m_cur;
      m_pend = (m_run == STABLE);
      m_ps = m_cur;
    end
  end

  // ---------------- compare process ----------------
  int n_checks = 0, n_errs = 0;
  int fv_total = 0, ch_total = 0, err_total = 0;
  int phase = 0, last_phase = 0;
  logic arm_async = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    #1;
    if (!clk) begin
      // Asynchronous reset: outputs must drop without waiting for a clock.
      if (arm_async) begin
        chk("async_value", value, 0);
        chk("async_dp_out", dp_out, 0);
        chk("async_frame_count", frame_count, 0);
        chk("async_err_count", err_count, 0);
      end
    end else begin
      chk("value", value, e_value);
      chk("dp_out", dp_out, e_dp);
      chk("frame_valid", frame_valid, e_fv);
      chk("changed", changed, e_ch);
      chk("seg_err", seg_err, e_err);
      chk("frame_count", frame_count, e_fc);
      chk("err_count", err_count, e_ec);
      if (frame_valid === 1'b1) fv_total++;
      if (changed === 1'b1) ch_total++;
      if (seg_err === 1'b1) err_total++;
      if (phase != last_phase) begin
        case (phase)
          1: begin chk("short_value", value, 0); chk("short_fv", fv_total, 0);
                   chk("short_fc", frame_count, 0); end
          2: begin chk("scan1_value", value, 16'h3C10); chk("scan1_fc", frame_count, 1);
                   chk("scan1_fv", fv_total, 1); chk("scan1_ch", ch_total, 1);
                   chk("scan1_dp", dp_out, 0); end
          3: begin chk("scan3_value", value, 16'h3C10); chk("scan3_fc", frame_count, 3);
                   chk("scan3_fv", fv_total, 3); chk("scan3_ch", ch_total, 1); end
          4: begin chk("inv_ec", err_count, 1); chk("inv_errs", err_total, 1);
                   chk("inv_fv", fv_total, 3); end
          5: begin chk("fix_value", value, 16'hFFFF); chk("fix_fc", frame_count, 4);
                   chk("fix_fv", fv_total, 4); chk("fix_ch", ch_total, 2); end
          6: begin chk("multi_ec", err_count, 2); chk("multi_errs", err_total, 2); end
          7: begin chk("blank_ec", err_count, 2); chk("blank_fc", frame_count, 4); end
          8: begin chk("rst_value", value, 16'h0001); chk("rst_dp", dp_out, 4'b0001);
                   chk("rst_fc", frame_count, 1); chk("rst_ec", err_count, 0); end
          default: ;
        endcase
        last_phase = phase;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    @(negedge clk);
    an = a; a_to_g = s; dp = d;
    repeat (n) @(posedge clk);
  endtask

  task automatic idle(input int n);
    put(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] dpl, input int hold);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = ~(4'b0001 << i);
      put(a, SEG[v[4*i +: 4]], ~dpl[i], hold);
    end
  endtask

  task automatic mark(input int p);
    @(negedge clk);
    phase = p;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int kind, hold;
    logic [3:0] a;
    logic [3:0] nib;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    idle(3);

    scan(16'h1234, 4'b0000, STABLE - 1); idle(8); mark(1);
    scan(16'h3C10, 4'b0000, 8); idle(6); mark(2);
    scan(16'h3C10, 4'b0000, 8); idle(4);
    scan(16'h3C10, 4'b0000, 8); idle(6); mark(3);

    put(4'b1110, SEG[15], 1'b1, 8);
    put(4'b1101, SEG[15], 1'b1, 8);
    put(4'b1011, 7'h7F,   1'b1, 8);
    put(4'b0111, SEG[15], 1'b1, 8);
    idle(6); mark(4);
    put(4'b1011, SEG[15], 1'b1, 8); idle(6); mark(5);

    put(4'b1100, SEG[0], 1'b1, 8); idle(6); mark(6);
    idle(10); mark(7);

    // Three digits of 0xABCD, then reset mid-frame.
    put(4'b1110, SEG[13], 1'b1, 8);
    put(4'b1101, SEG[12], 1'b1, 8);
    put(4'b1011, SEG[11], 1'b1, 8);
    @(negedge clk); arm_async = 1'b1; rst_n = 1'b0;
    an = 4'hF; a_to_g = 7'h7F; dp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; arm_async = 1'b0;
    idle(3);
    scan(16'h0001, 4'b0001, 8); idle(6); mark(8);

    // Randomized bus: valid digits, junk patterns, multi-strobe, blanks.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 9);
      nib  = 4'($urandom_range(0, 15));
      a    = ~(4'b0001 << $urandom_range(0, 3));
      case (kind)
        7:       put(a, 7'($urandom), 1'($urandom), hold);
        8:       put(4'($urandom), SEG[nib], 1'($urandom), hold);
        9:       idle(hold);
        default: put(a, SEG[nib], 1'($urandom), hold);
      endcase
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
